// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone classic-cycle initiator: FSM states,
// the queued command record and the response record.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic rsp_t make_rsp(input logic [31:0] rdata, input logic err,
                                    input logic timeout);
    rsp_t r;
    r.rdata   = rdata;
    r.err     = err;
    r.timeout = timeout;
    return r;
  endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags. A push while full is
// dropped; push and pop on the same edge are legal at any occupancy.
module wb_cmd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_master_initiator.sv
// Wishbone classic-cycle initiator: one bus cycle per queued command, with
// timeout abort, retry on err, and one response per command.
module wb_master_initiator
  import wb_master_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRIES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output state_t      fsm_state
);

  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  // Handshakes: cmd is taken on an edge with cmd_valid && cmd_ready; a
  // response is consumed on an edge with rsp_valid && rsp_ready, and its
  // fields stay stable while rsp_valid waits for rsp_ready.

  state_t        state;
  cmd_t          cmd_in;
  cmd_t          head;
  rsp_t          rsp_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          cur_we;
  logic [WW-1:0] wait_cnt;
  logic [RW-1:0] retry_cnt;

  assign cmd_in.addr  = cmd_addr;
  assign cmd_in.wdata = cmd_wdata;
  assign cmd_in.we    = cmd_we;

  assign cmd_ready   = !fifo_full;
  assign fifo_pop    = (state == IDLE) && !fifo_empty;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign fsm_state   = state;

  wb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      cur_we    <= 1'b0;
      wait_cnt  <= '0;
      retry_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            wb_adr_o  <= head.addr;
            wb_dat_o  <= head.wdata;
            wb_we_o   <= head.we;
            cur_we    <= head.we;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            state     <= REQ;
          end
        end

        REQ: begin
          // err beats ack; ack beats a timeout expiring on the same edge.
          if (wb_err_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wait_cnt <= '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= GAP;
            end else begin
              rsp_q     <= make_rsp('0, 1'b1, 1'b0);
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end else if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_q     <= make_rsp(cur_we ? '0 : wb_dat_i, 1'b0, 1'b0);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_q     <= make_rsp('0, 1'b1, 1'b1);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        GAP: begin
          wait_cnt <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= cur_we;
          state    <= REQ;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_initiator.sv
// Directed and randomized checks of wb_master_initiator against a
// behavioural slave plus an outcome model computed per command.
module tb_wb_master_initiator;

  localparam int T  = 16;
  localparam int MR = 2;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_SIL  = 2;
  localparam int K_BOTH = 3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  delay;
    logic [31:0] rdata;
  } beh_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic [7:0]  stb;
    logic [3:0]  att;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int cyc_n = 0;
  int acc_cycle = 0;

  beh_t             slv_q[$];
  beh_t             script[$];
  logic [EXP_W-1:0] exp_q[$];

  // per-transaction bus observations gathered by the slave
  int          stb_cnt  = 0;
  int          att_cnt  = 0;
  int          unstable = 0;
  int          viol     = 0;
  bit          seen     = 0;
  logic [31:0] obs_adr;
  logic [31:0] obs_dat;
  logic        obs_we;

  wb_master_initiator dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_we      (cmd_we),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .fsm_state   (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave responder: each stb attempt consumes one behaviour entry and
  // terminates it 'delay' cycles after stb first appears (never if silent).
  initial begin : slave
    beh_t cur;
    int   k;
    bit   in_att;
    in_att   = 0;
    k        = 0;
    cur      = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (rst) begin
        in_att = 0;
      end else begin
        if (wb_cyc_o !== wb_stb_o) viol++;
        if (wb_we_o && !wb_stb_o) viol++;
        if (wb_stb_o) begin
          if (!in_att) begin
            in_att = 1;
            k = 0;
            att_cnt++;
            if (slv_q.size() > 0) cur = slv_q.pop_front();
            else begin
              cur.kind  = 2'(K_SIL);
              cur.delay = '0;
              cur.rdata = '0;
            end
          end else k++;
          stb_cnt++;
          if (!seen) begin
            seen    = 1;
            obs_adr = wb_adr_o;
            obs_dat = wb_dat_o;
            obs_we  = wb_we_o;
          end else if (wb_adr_o !== obs_adr || wb_dat_o !== obs_dat || wb_we_o !== obs_we)
            unstable++;
          if (k == int'(cur.delay)) begin
            case (int'(cur.kind))
              K_ACK:  begin wb_ack_i = 1'b1; wb_dat_i = cur.rdata; end
              K_ERR:  wb_err_i = 1'b1;
              K_BOTH: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = cur.rdata; end
              default: ;
            endcase
          end
        end else in_att = 0;
      end
    end
  end

  function automatic beh_t mk(input int kind, input int delay, input logic [31:0] rdata);
    beh_t b;
    b.kind  = 2'(kind);
    b.delay = 8'(delay);
    b.rdata = rdata;
    return b;
  endfunction

  // Outcome model: walk the slave script attempt by attempt using the
  // bus rules (timeout after T stb cycles, MR retries, err beats ack).
  task automatic plan(input logic [31:0] a, input logic [31:0] d, input logic w);
    exp_t e;
    beh_t b;
    int   att;
    int   stb;
    bit   done;
    att = 0; stb = 0; done = 0;
    e = '0;
    e.addr = a; e.wdata = d; e.we = w;
    while (!done) begin
      if (att < script.size()) b = script[att];
      else b = mk(K_SIL, 0, 0);
      slv_q.push_back(b);
      att++;
      if (int'(b.kind) == K_SIL || int'(b.delay) >= T) begin
        stb += T; e.err = 1; e.to = 1; done = 1;
      end else begin
        stb += int'(b.delay) + 1;
        if (int'(b.kind) == K_ERR || int'(b.kind) == K_BOTH) begin
          if (att - 1 >= MR) begin e.err = 1; done = 1; end
        end else begin
          e.rdata = w ? 32'h0 : b.rdata;
          done = 1;
        end
      end
    end
    e.stb = 8'(stb);
    e.att = 4'(att);
    exp_q.push_back(e);
    script.delete();
  endtask

  // driver tasks: called and returning at posedge+1
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] d, input logic w);
    int n;
    bit ok;
    n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_we = w;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    ok = cmd_ready;
    check("cmd_accept", ok, 1);
    @(posedge clk);
    #1;
    acc_cycle = cyc_n;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input bit check_lat);
    exp_t e;
    int   n;
    bit   got;
    n = 0;
    e = exp_q.pop_front();
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    got = rsp_valid;
    check("rsp_arrives", got, 1);
    if (got) begin
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", rsp_err, e.err);
      check("rsp_timeout", rsp_timeout, e.to);
      check("stb_cycles", stb_cnt, e.stb);
      check("attempts", att_cnt, e.att);
      check("wb_adr", obs_adr, e.addr);
      check("wb_we", obs_we, e.we);
      if (e.we) check("wb_dat", obs_dat, e.wdata);
      check("bus_stable", unstable, 0);
      if (check_lat) check("latency", cyc_n - acc_cycle, 1 + int'(e.stb) + int'(e.att) - 1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    stb_cnt = 0; att_cnt = 0; seen = 0; unstable = 0;
  endtask

  task automatic one_cmd(input logic [31:0] a, input logic [31:0] d, input logic w);
    plan(a, d, w);
    send_cmd(a, d, w);
    get_rsp(1);
  endtask

  initial begin : main
    int n;
    int rv_seen;
    bit got;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_we = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // read, ack two cycles after stb
    script.push_back(mk(K_ACK, 2, 32'hDEADBEEF));
    one_cmd(32'h10, 32'h0, 1'b0);
    // write, immediate ack
    script.push_back(mk(K_ACK, 0, 32'h12345678));
    one_cmd(32'h4, 32'hA5A5A5A5, 1'b1);
    // err on every attempt
    repeat (3) script.push_back(mk(K_ERR, 0, 0));
    one_cmd(32'h20, 32'h0, 1'b0);
    // err twice then ack
    script.push_back(mk(K_ERR, 1, 0));
    script.push_back(mk(K_ERR, 0, 0));
    script.push_back(mk(K_ACK, 1, 32'hCAFEF00D));
    one_cmd(32'h24, 32'h0, 1'b0);
    // silent slave
    script.push_back(mk(K_SIL, 0, 0));
    one_cmd(32'h28, 32'h11, 1'b1);
    // ack on the timeout edge, and one cycle too late
    script.push_back(mk(K_ACK, T - 1, 32'h0BADF00D));
    one_cmd(32'h2C, 32'h0, 1'b0);
    script.push_back(mk(K_ACK, T, 32'h0BADF00D));
    one_cmd(32'h30, 32'h0, 1'b0);
    // ack and err together
    repeat (3) script.push_back(mk(K_BOTH, 0, 32'h77777777));
    one_cmd(32'h34, 32'h0, 1'b0);

    // backpressure: one held response plus four queued fills the FIFO
    for (int i = 0; i < 6; i++) begin
      script.push_back(mk(K_ACK, 0, 32'hB0000000 + 32'(i)));
      plan(32'h100 + 32'(4 * i), 32'h0, 1'b0);
    end
    for (int i = 0; i < 5; i++) send_cmd(32'h100 + 32'(4 * i), 32'h0, 1'b0);
    check("bp_full", cmd_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_full_held", cmd_ready, 0);
    check("bp_rsp_held", rsp_valid, 1);
    fork
      send_cmd(32'h114, 32'h0, 1'b0);
      repeat (6) get_rsp(0);
    join

    // randomized commands
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      for (int j = 0; j < 3; j++) begin
        int kr;
        int dr;
        int kind;
        int dly;
        kr = $urandom_range(0, 9);
        dr = $urandom_range(0, 9);
        kind = (kr < 6) ? K_ACK : (kr < 8) ? K_ERR : (kr < 9) ? K_BOTH : K_SIL;
        dly  = (dr < 8) ? $urandom_range(0, 3) : (dr == 8) ? T - 1 : T;
        script.push_back(mk(kind, dly, $urandom));
      end
      one_cmd(a, d, w);
    end

    // async reset mid-transaction with two commands queued
    slv_q.delete();
    send_cmd(32'h200, 32'h0, 1'b0);
    send_cmd(32'h204, 32'h0, 1'b0);
    send_cmd(32'h208, 32'h0, 1'b0);
    n = 0;
    while (!wb_stb_o && n < 50) begin @(posedge clk); #1; n++; end
    got = wb_stb_o;
    check("rst_test_stb_up", got, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_cyc", wb_cyc_o, 0);
    check("async_rst_stb", wb_stb_o, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    check("async_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stb_cnt = 0; att_cnt = 0; seen = 0; unstable = 0;
    rsp_ready = 1'b1;
    rv_seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (rsp_valid) rv_seen++;
    end
    rsp_ready = 1'b0;
    check("post_rst_no_rsp", rv_seen, 0);
    check("post_rst_no_stb", stb_cnt, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("bus_protocol", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_master_initiator.md
# wb_master_initiator

Wishbone classic-cycle bus master that converts a valid/ready command stream into single Wishbone read/write cycles and returns one response per command. It is the initiator end of the host-side Wishbone bus, driving `cyc/stb/we/adr/dat` and consuming `ack/err/dat_i` from a responder. It buffers commands in a small FIFO, times out unresponsive slaves, and retries on bus error.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 16: cycles `stb` may stay high without `ack`/`err` before abort; ≥2.
- `MAX_RETRIES`, 2: re-issues after `err` before reporting error; 0 disables retry.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO not full.
- `cmd_addr` in 32: target address.
- `cmd_wdata` in 32: write data.
- `cmd_we` in 1: 1 write, 0 read.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: read data; 0 for writes and failures.
- `rsp_err` out 1: transaction failed (err after retries, or timeout).
- `rsp_timeout` out 1: failure was a timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone strobes.
- `wb_adr_o`, `wb_dat_o` out 32: Wishbone address / write data.
- `wb_dat_i` in 32: read data.
- `wb_ack_i`, `wb_err_i` in 1: slave termination.

## Operation
- Reset: all outputs 0, `cmd_ready` 1, FIFO emptied, FSM in IDLE, counters 0.
- Command accepted on the edge where `cmd_valid && cmd_ready`; `cmd_ready = !full`.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into the address/data/we registers, clear the retry counter, go to REQ.
  - REQ: `wb_cyc_o = wb_stb_o = 1`; `adr/dat/we` held stable. On sampled `err` with retries < MAX_RETRIES: retry++, go to GAP. On `err` with retries exhausted: go to RESP with `rsp_err = 1`. On `ack`: go to RESP and capture `wb_dat_i` if read. On wait counter = TIMEOUT_CYCLES-1: go to RESP with `rsp_err = rsp_timeout = 1`.
  - GAP: one cycle with `cyc/stb` low, then REQ. The wait counter clears.
  - RESP: `rsp_valid = 1`, fields stable; on `rsp_ready` go to IDLE.
- `err` wins over a simultaneous `ack`. `ack` on the same edge as timeout expiry counts as success.
- `wb_*` outputs are registered. Outside REQ, `wb_adr_o`/`wb_dat_o` hold their last values and `wb_we_o` is 0.
- FIFO push and pop on the same edge are legal at any occupancy, including full (push accepted only if `cmd_ready` was 1 that cycle).
- Pointers wrap modulo CMD_DEPTH. Count width is `$clog2(CMD_DEPTH)+1`.

## Timing
- Command accepted at edge E0 into an empty FIFO in IDLE: pop at E1, `cyc/stb` high after E1.
- `ack` high in the following cycle → at E2 `cyc/stb` drop and `rsp_valid` rises. Minimum command-to-response latency is 2 cycles.
- Wait counter counts cycles with `stb` high. Abort occurs on the TIMEOUT_CYCLES-th cycle without termination, so `stb` stays high exactly TIMEOUT_CYCLES cycles.
- One outstanding bus transaction; no pipelining. IDLE costs one cycle between transactions.
- Asynchronous `rst` mid-transaction: `cyc/stb` fall immediately, in-flight and queued commands are discarded, and no response is produced.

## Structure
- Package `wb_master_pkg`: FSM state enum (IDLE, REQ, GAP, RESP), command struct (addr, wdata, we), response struct (rdata, err, timeout).
- Sub-module `wb_cmd_fifo`: parameterised synchronous FIFO (width 65, depth CMD_DEPTH) with full/empty outputs. The FSM lives in the top.

## Test plan
- Read: cmd addr 0x10, slave acks 2 cycles after `stb` with 0xDEADBEEF → one `rsp_valid`, `rsp_rdata` = 0xDEADBEEF, `err` = 0, `stb` high exactly 3 cycles.
- Write: cmd addr 0x4, data 0xA5A5A5A5, we = 1, immediate ack → `wb_we_o` = 1, `wb_dat_o` = 0xA5A5A5A5 during `stb`, response `rdata` = 0, `err` = 0.
- Error/retry: slave errs 3 times with MAX_RETRIES = 2 → 3 `stb` pulses separated by 1-cycle gaps, `rsp_err` = 1, `rsp_timeout` = 0. Errs twice then acks → `err` = 0.
- Timeout: slave silent → `stb` high 16 cycles, then `rsp_err` = `rsp_timeout` = 1. Ack and err both high → `rsp_err` = 1.
- Backpressure: push 6 commands with `rsp_ready` = 0 → `cmd_ready` low once 4 are queued behind the held response. Release `rsp_ready` → responses return in order with correct data, FIFO wraps correctly.
- Reset: assert `rst` while `stb` is high with 2 queued commands → `cyc/stb` 0 same cycle, no `rsp_valid` after release, `cmd_ready` = 1.
